// File: rtl/gpio_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_pad_pkg
// Brief   : Shared FSM state, drive-mode encodings and default parameters
// Rev     : 1.0
// ============================================================================
package gpio_pad_pkg;

    localparam int DEF_NUM_PADS   = 8;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_TURN_CYC   = 2;

    localparam logic [2:0] DM_SAFE   = 3'b001;
    localparam logic [2:0] DM_STRONG = 3'b110;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_ENABLE = 3'd1,
        ST_IDLE   = 3'd2,
        ST_TURN   = 3'd3,
        ST_APPLY  = 3'd4,
        ST_HOLD   = 3'd5
    } gpio_state_e;

endpackage
`default_nettype wire

// File: rtl/gpio_pad_cfg_reg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_pad_cfg_reg
// Brief   : Per-pad {oe_n, inp_dis, dm} storage with write-enable and force-safe
// Rev     : 1.0
// ============================================================================
module gpio_pad_cfg_reg
    import gpio_pad_pkg::*;
#(
    parameter int NUM_PADS = DEF_NUM_PADS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  force_safe_i,
    input  logic [NUM_PADS-1:0]   we_i,
    input  logic                  dm_we_i,
    input  logic                  oe_n_i,
    input  logic                  inp_dis_i,
    input  logic [2:0]            dm_i,
    output logic [NUM_PADS-1:0]   oe_n_o,
    output logic [NUM_PADS-1:0]   inp_dis_o,
    output logic [3*NUM_PADS-1:0] dm_o
);

    generate
        for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
            logic       oe_n_q;
            logic       inp_dis_q;
            logic [2:0] dm_q;

            // force_safe outranks a write so a brown-out can never let a config land
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    oe_n_q    <= 1'b1;
                    inp_dis_q <= 1'b1;
                    dm_q      <= DM_SAFE;
                end else if (force_safe_i) begin
                    oe_n_q    <= 1'b1;
                    inp_dis_q <= 1'b1;
                    dm_q      <= DM_SAFE;
                end else if (we_i[i]) begin
                    oe_n_q    <= oe_n_i;
                    inp_dis_q <= inp_dis_i;
                    if (dm_we_i) begin
                        dm_q <= dm_i;
                    end
                end
            end

            assign oe_n_o[i]        = oe_n_q;
            assign inp_dis_o[i]     = inp_dis_q;
            assign dm_o[3*i +: 3]   = dm_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gpio_pad_ctrl
// Brief   : Power-up, hold and glitch-free reconfiguration sequencer for GPIO pads
// Rev     : 1.0
// ============================================================================
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int NUM_PADS   = DEF_NUM_PADS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TURN_CYC   = DEF_TURN_CYC,
    // one spare bit so that out-of-range indices are always expressible
    localparam int IDX_W     = $clog2(NUM_PADS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pwr_ok,
    input  logic                  hold_req,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic                  cfg_dir,
    input  logic [2:0]            cfg_dm,
    output logic                  pad_enable_h,
    output logic                  pad_hld_h_n,
    output logic [NUM_PADS-1:0]   pad_oe_n,
    output logic [NUM_PADS-1:0]   pad_inp_dis,
    output logic [3*NUM_PADS-1:0] pad_dm,
    output logic                  ctrl_busy,
    output logic                  cfg_err
);

    localparam int               MAX_CYC     = (SETTLE_CYC > TURN_CYC) ? SETTLE_CYC : TURN_CYC;
    localparam int               CNT_W       = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LIMIT   = IDX_W'(NUM_PADS);

    gpio_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [2:0]       dm_q, dm_d;
    logic             err_q, err_d;

    logic                w_accept;
    logic                w_turn_wr;
    logic                w_apply_wr;
    logic                w_force_safe;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [NUM_PADS-1:0] w_we;

    assign cfg_ready = (state_q == ST_IDLE) && !hold_req && pwr_ok;
    assign w_accept  = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        dm_d       = dm_q;
        err_d      = err_q;
        w_turn_wr  = 1'b0;
        w_apply_wr = 1'b0;
        if (!pwr_ok) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_ENABLE;
                    cnt_d   = '0;
                end
                ST_ENABLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (hold_req) begin
                        state_d = ST_HOLD;
                    end else if (w_accept) begin
                        if (cfg_idx < IDX_LIMIT) begin
                            idx_d     = cfg_idx;
                            dir_d     = cfg_dir;
                            dm_d      = cfg_dm;
                            cnt_d     = '0;
                            state_d   = ST_TURN;
                            w_turn_wr = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                // new values land on APPLY entry, giving TURN_CYC+1 cycles of latency
                ST_TURN: begin
                    if (cnt_q == TURN_LAST) begin
                        state_d    = ST_APPLY;
                        cnt_d      = '0;
                        w_apply_wr = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_APPLY: begin
                    state_d = hold_req ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!hold_req) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            dm_q    <= DM_SAFE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            dm_q    <= dm_d;
            err_q   <= err_d;
        end
    end

    assign w_force_safe = (state_q == ST_OFF) || !pwr_ok;
    assign w_wr_idx     = w_turn_wr ? cfg_idx : idx_q;

    generate
        for (genvar i = 0; i < NUM_PADS; i++) begin : g_we
            assign w_we[i] = (w_turn_wr || w_apply_wr) && (w_wr_idx == IDX_W'(i));
        end
    endgenerate

    gpio_pad_cfg_reg #(
        .NUM_PADS (NUM_PADS)
    ) u_cfg_reg (
        .clk          (clk),
        .reset        (reset),
        .force_safe_i (w_force_safe),
        .we_i         (w_we),
        .dm_we_i      (w_apply_wr),
        .oe_n_i       (w_apply_wr ? dir_q : 1'b1),
        .inp_dis_i    (w_apply_wr ? ~dir_q : 1'b1),
        .dm_i         (dm_q),
        .oe_n_o       (pad_oe_n),
        .inp_dis_o    (pad_inp_dis),
        .dm_o         (pad_dm)
    );

    assign pad_enable_h = (state_q != ST_OFF);
    assign pad_hld_h_n  = (state_q == ST_IDLE) || (state_q == ST_TURN) || (state_q == ST_APPLY);
    assign ctrl_busy    = (state_q != ST_IDLE);
    assign cfg_err      = err_q;

endmodule
`default_nettype wire
